issue_scheduler: RTL and testbench
==================================

Name: issue_scheduler

Overview:
- Wakeup/select stage between the shared entry buffer and the two execution ports.
- Each cycle, scans all BUF_SIZE entries and picks up to two ready ones, oldest first, subject to port capability and divider occupancy.
- Drives is_valid_execution/waked_tags/ex_modes into the buffer and the EX stage.
- Tracks in-flight issues so no entry is issued twice before the buffer's state update lands.

Parameters:
- BUF_SIZE_LOG, 4, log2 of buffer depth (shared package value).
- BUF_SIZE, 2**BUF_SIZE_LOG, number of buffer entries.
- DIV_LATENCY, 8, cycles the non-pipelined divider stays occupied after a DIV issue (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- entries  in  entry[BUF_SIZE]  current buffer contents (package struct).
- oldest_tag  in  BUF_SIZE_LOG+1  tag of the oldest uncommitted instruction (age base).
- flush  in  1  misprediction flush; drops in-flight bookkeeping.
- ex_ready  in  1[2]  per-port EX acceptance; 0 blocks issue on that port.
- is_valid_execution  out  1[2]  issue valid per port (registered).
- waked_tags  out  BUF_SIZE_LOG+1 [2]  tag of issued entry per port.
- issue_index  out  BUF_SIZE_LOG [2]  buffer index of issued entry per port.
- ex_modes  out  ex_mode[2]  EX_GEN_ADDR for address generation, else EX_NORMAL.
- div_busy  out  1  divider occupied (observability).

Behaviour:
- Reset, and flush, the same cycle: all outputs 0 (ex_modes = EX_NORMAL, tags/indexes 0); pending mask cleared; div counter 0.
- Candidate rules for entry i (state ≠ S_NOT_USED, pending[i] = 0):
  - ALU/BRANCH/MUL/DIV: e_state = S_NOT_EXECUTED, J_rdy & K_rdy; mode EX_NORMAL.
  - STORE: e_state = S_NOT_EXECUTED, J_rdy & K_rdy; mode EX_GEN_ADDR.
  - LOAD address phase: e_state = S_NOT_EXECUTED, J_rdy; mode EX_GEN_ADDR.
  - LOAD memory phase: e_state = S_ADDR_GENERATED, A_rdy, number_of_early_store_ops = 0; mode EX_NORMAL.
- Port capability:
  - Port 0 accepts ALU, BRANCH, MUL, DIV.
  - Port 1 accepts ALU, LOAD, STORE.
  - DIV is not a candidate while div_busy = 1.
- Age is (tag − oldest_tag) mod 2^(BUF_SIZE_LOG+1), unsigned; smaller is older. Ties cannot occur (tags are unique).
- Select:
  - Port 0 takes its oldest eligible candidate.
  - Port 1 takes its oldest eligible candidate excluding the one chosen by port 0.
  - An ALU op may go to either port: port 0 is evaluated first, so two ALU ops fill both ports.
  - If ex_ready[p] = 0, port p issues nothing that cycle and its candidate stays eligible for the other port only if type-compatible.
- Outputs are registered: a selection at edge n is visible from edge n until edge n+1. No selection means valid 0; tag/index hold their last value.
- Pending mask:
  - Bit i sets when entry i is issued.
  - Bit i clears when entries[i].e_state differs from its value at issue, or e_state = S_NOT_USED (commit/reallocation).
  - A bit set for 2 consecutive cycles without a state change is a protocol error; flag via assertion only.
- Divider counter:
  - Loads DIV_LATENCY on a DIV issue and decrements to 0.
  - div_busy = (counter ≠ 0).
  - A second DIV becomes eligible in the cycle the counter reaches 0.
- Wrap-around: age arithmetic is modular, so oldest_tag near 2^(BUF_SIZE_LOG+1)−1 with younger tags wrapped to small values must still select correctly.
- Simultaneous events:
  - Flush wins over issue.
  - Reset wins over everything.
  - An entry reallocated (new tag) while pending clears pending via the state change through S_NOT_USED, or via a tag compare against the stored tag.

Decomposition:
- Package: BUF_SIZE_LOG, BUF_SIZE, state, unit, ex_mode, entry (moved there from the buffer file, which imports it).
- Sub-module oldest_picker: combinational, takes a BUF_SIZE-bit eligible mask plus tags and oldest_tag; returns found, index, tag. Instantiated twice, the second with port 0's pick masked out.

Test Plan:
- Two ready ALU entries with tags 3 and 5, oldest_tag 2 → port 0 issues tag 3, port 1 issues tag 5, both EX_NORMAL, one cycle later.
- DIV tag 4 ready, another DIV tag 6 ready, DIV_LATENCY 8 → tag 4 issues; tag 6 is blocked for 8 cycles (div_busy = 1); tag 6 issues once the counter hits 0.
- LOAD tag 7: S_NOT_EXECUTED with J_rdy → issue EX_GEN_ADDR on port 1. Later S_ADDR_GENERATED with number_of_early_store_ops = 2 → no issue; after it becomes 0 → issue EX_NORMAL.
- oldest_tag 30, ready ALU tags 31 and 1 (wrapped) → 31 on port 0, 1 on port 1.
- Entry issued, e_state held at S_NOT_EXECUTED one extra cycle → no re-issue on that cycle; flush asserted with candidates ready → both valid outputs 0 next cycle and pending cleared.
- ex_ready = {0,1} with ready ALU tag 2 and STORE tag 3 → port 1 gets tag 2 (older ALU), store waits; reset mid-operation with div_busy = 1 → div_busy 0 the next cycle.

Source files
------------

// File: rtl/issue_scheduler_pkg.sv
// Shared types for the issue stage and the entry buffer.
//   BUF_SIZE_LOG / BUF_SIZE : buffer depth (log2 / entries)
//   TAG_W                   : instruction tag width (one extra bit for age wrap)
//   state_e, unit_e         : entry lifecycle state and functional unit class
//   ex_mode_e               : EX stage operating mode for an issued op
//   entry_t                 : one buffer entry as seen by the scheduler
//   age_of()                : modular age of a tag relative to the oldest tag
package issue_scheduler_pkg;

  localparam int BUF_SIZE_LOG = 4;
  localparam int BUF_SIZE     = 2 ** BUF_SIZE_LOG;
  localparam int TAG_W        = BUF_SIZE_LOG + 1;

  typedef logic [TAG_W-1:0]        tag_t;
  typedef logic [BUF_SIZE_LOG-1:0] idx_t;

  typedef enum logic [1:0] {
    S_NOT_USED,
    S_NOT_EXECUTED,
    S_ADDR_GENERATED,
    S_EXECUTED
  } state_e;

  typedef enum logic [2:0] {
    U_ALU,
    U_BRANCH,
    U_MUL,
    U_DIV,
    U_LOAD,
    U_STORE
  } unit_e;

  typedef enum logic {
    EX_NORMAL,
    EX_GEN_ADDR
  } ex_mode_e;

  typedef struct packed {
    state_e                  e_state;
    unit_e                   unit;
    tag_t                    tag;
    logic                    j_rdy;
    logic                    k_rdy;
    logic                    a_rdy;
    logic [BUF_SIZE_LOG-1:0] number_of_early_store_ops;
  } entry_t;

  // Tags wrap modulo 2^TAG_W, so the unsigned difference orders them by age.
  function automatic tag_t age_of(input tag_t tag, input tag_t oldest);
    return tag - oldest;
  endfunction

endpackage

// File: rtl/issue_scheduler_oldest_picker.sv
// Combinational oldest-first selector.
//   eligible_i   : per-entry eligibility mask
//   tags_i       : per-entry tags
//   oldest_tag_i : age base
//   found_o      : at least one eligible entry
//   index_o      : buffer index of the oldest eligible entry
//   tag_o        : tag of that entry
module issue_scheduler_oldest_picker
  import issue_scheduler_pkg::*;
(
  input  logic [BUF_SIZE-1:0]   eligible_i,
  input  tag_t [BUF_SIZE-1:0]   tags_i,
  input  tag_t                  oldest_tag_i,
  output logic                  found_o,
  output idx_t                  index_o,
  output tag_t                  tag_o
);

  tag_t best_age;

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    found_o  = 1'b0;
    index_o  = '0;
    tag_o    = '0;
    best_age = '1;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (eligible_i[i] && (!found_o || age_of(tags_i[i], oldest_tag_i) < best_age)) begin
        found_o  = 1'b1;
        index_o  = idx_t'(i);
        tag_o    = tags_i[i];
        best_age = age_of(tags_i[i], oldest_tag_i);
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Wakeup/select stage between the entry buffer and two execution ports.
//   clk, reset_i          : clock, synchronous active-high reset
//   entries_i             : current buffer contents
//   oldest_tag_i          : tag of the oldest uncommitted instruction
//   flush_i               : misprediction flush
//   ex_ready_i[p]         : EX port p can accept an op this cycle
//   is_valid_execution_o  : registered issue valid per port
//   waked_tags_o          : tag of the issued entry per port
//   issue_index_o         : buffer index of the issued entry per port
//   ex_modes_o            : EX_GEN_ADDR for address generation, else EX_NORMAL
//   div_busy_o            : non-pipelined divider occupied
// Port 0 serves ALU/BRANCH/MUL/DIV, port 1 serves ALU/LOAD/STORE.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int DIV_LATENCY = 8
) (
  input  logic      clk,
  input  logic      reset_i,
  input  entry_t    entries_i [BUF_SIZE],
  input  tag_t      oldest_tag_i,
  input  logic      flush_i,
  input  logic [1:0] ex_ready_i,
  output logic [1:0] is_valid_execution_o,
  output tag_t      waked_tags_o [2],
  output idx_t      issue_index_o [2],
  output ex_mode_e  ex_modes_o [2],
  output logic      div_busy_o
);

  localparam int CNT_W = $clog2(DIV_LATENCY + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  // Registered state
  logic [1:0]          valid_q, valid_d;
  tag_t                tag_q [2], tag_d [2];
  idx_t                idx_q [2], idx_d [2];
  ex_mode_e            mode_q [2], mode_d [2];
  logic [BUF_SIZE-1:0] pending_q, pending_d;
  logic [BUF_SIZE-1:0] held_q, held_d;
  state_e              pst_q [BUF_SIZE], pst_d [BUF_SIZE];
  tag_t                ptag_q [BUF_SIZE], ptag_d [BUF_SIZE];
  cnt_t                div_cnt_q, div_cnt_d;

  // Candidate evaluation
  logic [BUF_SIZE-1:0] cand, cap0, cap1, pend_eff, elig0, elig1, mask0;
  ex_mode_e            cand_mode [BUF_SIZE];
  tag_t [BUF_SIZE-1:0] tags;
  logic                div_busy;

  logic found0, found1;
  idx_t idx0, idx1;
  tag_t ptag0, ptag1;

  assign div_busy = (div_cnt_q != '0);

  always_comb begin
    cand      = '0;
    cap0      = '0;
    cap1      = '0;
    pend_eff  = '0;
    tags      = '0;
    cand_mode = '{default: EX_NORMAL};
    for (int i = 0; i < BUF_SIZE; i++) begin
      logic ne, jk, rdy;
      ne  = (entries_i[i].e_state == S_NOT_EXECUTED);
      jk  = entries_i[i].j_rdy & entries_i[i].k_rdy;
      rdy = 1'b0;
      tags[i] = entries_i[i].tag;
      // A pending bit stops blocking as soon as the buffer moves the entry on
      // (state change, free, or reallocation under a new tag).
      pend_eff[i] = pending_q[i]
                  & (entries_i[i].e_state == pst_q[i])
                  & (entries_i[i].tag == ptag_q[i])
                  & (entries_i[i].e_state != S_NOT_USED);
      case (entries_i[i].unit)
        U_ALU: begin
          rdy = ne & jk;
          cap0[i] = 1'b1;
          cap1[i] = 1'b1;
        end
        U_BRANCH, U_MUL: begin
          rdy = ne & jk;
          cap0[i] = 1'b1;
        end
        U_DIV: begin
          rdy = ne & jk & ~div_busy;
          cap0[i] = 1'b1;
        end
        U_LOAD: begin
          cap1[i] = 1'b1;
          if (ne) begin
            rdy = entries_i[i].j_rdy;
            cand_mode[i] = EX_GEN_ADDR;
          end else if (entries_i[i].e_state == S_ADDR_GENERATED) begin
            rdy = entries_i[i].a_rdy & (entries_i[i].number_of_early_store_ops == '0);
          end
        end
        U_STORE: begin
          rdy = ne & jk;
          cap1[i] = 1'b1;
          cand_mode[i] = EX_GEN_ADDR;
        end
        default: rdy = 1'b0;
      endcase
      cand[i] = rdy & ~pend_eff[i] & (entries_i[i].e_state != S_NOT_USED);
    end
  end

  assign elig0 = cand & cap0 & {BUF_SIZE{ex_ready_i[0]}};
  assign mask0 = found0 ? (BUF_SIZE'(1) << idx0) : '0;
  assign elig1 = cand & cap1 & ~mask0 & {BUF_SIZE{ex_ready_i[1]}};

  issue_scheduler_oldest_picker u_pick0 (
    .eligible_i   (elig0),
    .tags_i       (tags),
    .oldest_tag_i (oldest_tag_i),
    .found_o      (found0),
    .index_o      (idx0),
    .tag_o        (ptag0)
  );

  issue_scheduler_oldest_picker u_pick1 (
    .eligible_i   (elig1),
    .tags_i       (tags),
    .oldest_tag_i (oldest_tag_i),
    .found_o      (found1),
    .index_o      (idx1),
    .tag_o        (ptag1)
  );

  // Next-state
  always_comb begin
    valid_d   = {found1, found0};
    tag_d     = tag_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    pending_d = pend_eff;
    held_d    = pend_eff;
    pst_d     = pst_q;
    ptag_d    = ptag_q;
    div_cnt_d = div_busy ? div_cnt_q - cnt_t'(1) : div_cnt_q;

    if (found0) begin
      tag_d[0]        = ptag0;
      idx_d[0]        = idx0;
      mode_d[0]       = cand_mode[idx0];
      pending_d[idx0] = 1'b1;
      pst_d[idx0]     = entries_i[idx0].e_state;
      ptag_d[idx0]    = ptag0;
      if (entries_i[idx0].unit == U_DIV) div_cnt_d = cnt_t'(DIV_LATENCY);
    end
    if (found1) begin
      tag_d[1]        = ptag1;
      idx_d[1]        = idx1;
      mode_d[1]       = cand_mode[idx1];
      pending_d[idx1] = 1'b1;
      pst_d[idx1]     = entries_i[idx1].e_state;
      ptag_d[idx1]    = ptag1;
    end

    if (flush_i) begin
      valid_d   = '0;
      tag_d     = '{default: '0};
      idx_d     = '{default: '0};
      mode_d    = '{default: EX_NORMAL};
      pending_d = '0;
      held_d    = '0;
      div_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      valid_q   <= '0;
      tag_q     <= '{default: '0};
      idx_q     <= '{default: '0};
      mode_q    <= '{default: EX_NORMAL};
      pending_q <= '0;
      held_q    <= '0;
      div_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      held_q    <= held_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // NOTE: the issue-time state/tag snapshot is only read while its pending bit
  // is set, and that bit is reset, so the snapshot array itself needs no reset.
  always_ff @(posedge clk) begin
    pst_q  <= pst_d;
    ptag_q <= ptag_d;
  end

  assign is_valid_execution_o = valid_q;
  assign waked_tags_o         = tag_q;
  assign issue_index_o        = idx_q;
  assign ex_modes_o           = mode_q;
  assign div_busy_o           = div_busy;

  // The buffer must move an issued entry on within one cycle of seeing it.
  a_pending_stuck : assert property (@(posedge clk) disable iff (reset_i || flush_i)
    (pend_eff & held_q) == '0);

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  localparam int DIV_LAT = 8;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       flush_i;
  logic [1:0] ex_ready_i;
  tag_t       oldest_tag_i;
  entry_t     ent [BUF_SIZE];
  logic [1:0] is_valid_execution_o;
  tag_t       waked_tags_o [2];
  idx_t       issue_index_o [2];
  ex_mode_e   ex_modes_o [2];
  logic       div_busy_o;

  always #5 clk = ~clk;

  issue_scheduler #(.DIV_LATENCY(DIV_LAT)) dut (
    .clk                  (clk),
    .reset_i              (reset_i),
    .entries_i            (ent),
    .oldest_tag_i         (oldest_tag_i),
    .flush_i              (flush_i),
    .ex_ready_i           (ex_ready_i),
    .is_valid_execution_o (is_valid_execution_o),
    .waked_tags_o         (waked_tags_o),
    .issue_index_o        (issue_index_o),
    .ex_modes_o           (ex_modes_o),
    .div_busy_o           (div_busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit       m_pend [BUF_SIZE];
  state_e   m_pst  [BUF_SIZE];
  tag_t     m_ptag [BUF_SIZE];
  int       m_div = 0;
  bit       m_valid [2];
  tag_t     m_tag [2];
  idx_t     m_idx [2];
  ex_mode_e m_mode [2];
  bit       s_keep [BUF_SIZE];
  bit       s_found [2];
  int       s_idx [2];

  function automatic bit eligible(input int i, input int p);
    entry_t e  = ent[i];
    bit     ne = (e.e_state == S_NOT_EXECUTED);
    if (s_keep[i] || e.e_state == S_NOT_USED) return 1'b0;
    if (p == 0 && !(e.unit inside {U_ALU, U_BRANCH, U_MUL, U_DIV})) return 1'b0;
    if (p == 1 && !(e.unit inside {U_ALU, U_LOAD, U_STORE})) return 1'b0;
    case (e.unit)
      U_DIV:   return ne && e.j_rdy && e.k_rdy && m_div == 0;
      U_LOAD:  return (ne && e.j_rdy) ||
                      (e.e_state == S_ADDR_GENERATED && e.a_rdy && e.number_of_early_store_ops == 0);
      default: return ne && e.j_rdy && e.k_rdy;
    endcase
  endfunction

  function automatic ex_mode_e mode_of(input int i);
    if (ent[i].unit == U_STORE) return EX_GEN_ADDR;
    if (ent[i].unit == U_LOAD && ent[i].e_state == S_NOT_EXECUTED) return EX_GEN_ADDR;
    return EX_NORMAL;
  endfunction

  task automatic model_select();
    for (int i = 0; i < BUF_SIZE; i++)
      s_keep[i] = m_pend[i] && ent[i].e_state == m_pst[i] && ent[i].tag == m_ptag[i] &&
                  ent[i].e_state != S_NOT_USED;
    for (int p = 0; p < 2; p++) begin
      int best = 1000;
      s_found[p] = 1'b0;
      s_idx[p]   = 0;
      if (ex_ready_i[p]) begin
        for (int i = 0; i < BUF_SIZE; i++) begin
          int age = (int'(ent[i].tag) - int'(oldest_tag_i) + 64) % 32;
          if (p == 1 && s_found[0] && s_idx[0] == i) continue;
          if (eligible(i, p) && age < best) begin
            best = age;
            s_found[p] = 1'b1;
            s_idx[p] = i;
          end
        end
      end
    end
  endtask

  task automatic model_commit();
    if (reset_i || flush_i) begin
      for (int p = 0; p < 2; p++) begin
        m_valid[p] = 1'b0; m_tag[p] = '0; m_idx[p] = '0; m_mode[p] = EX_NORMAL;
      end
      for (int i = 0; i < BUF_SIZE; i++) m_pend[i] = 1'b0;
      m_div = 0;
    end else begin
      bit new_div = s_found[0] && ent[s_idx[0]].unit == U_DIV;
      for (int i = 0; i < BUF_SIZE; i++) m_pend[i] = s_keep[i];
      for (int p = 0; p < 2; p++) begin
        m_valid[p] = s_found[p];
        if (s_found[p]) begin
          m_tag[p]  = ent[s_idx[p]].tag;
          m_idx[p]  = idx_t'(s_idx[p]);
          m_mode[p] = mode_of(s_idx[p]);
          m_pend[s_idx[p]] = 1'b1;
          m_pst[s_idx[p]]  = ent[s_idx[p]].e_state;
          m_ptag[s_idx[p]] = ent[s_idx[p]].tag;
        end
      end
      if (new_div) m_div = DIV_LAT;
      else if (m_div > 0) m_div--;
    end
  endtask

  task automatic check_outputs();
    for (int p = 0; p < 2; p++) begin
      check($sformatf("valid%0d", p), 32'(is_valid_execution_o[p]), 32'(m_valid[p]));
      check($sformatf("tag%0d", p), 32'(waked_tags_o[p]), 32'(m_tag[p]));
      check($sformatf("index%0d", p), 32'(issue_index_o[p]), 32'(m_idx[p]));
      if (m_valid[p]) check($sformatf("mode%0d", p), 32'(ex_modes_o[p]), 32'(m_mode[p]));
    end
    check("div_busy", 32'(div_busy_o), 32'(m_div != 0));
  endtask

  // Buffer reaction: an issued entry advances in the same cycle it is seen.
  task automatic buffer_update();
    for (int p = 0; p < 2; p++) begin
      if (m_valid[p]) begin
        int i = int'(m_idx[p]);
        if (ent[i].unit == U_LOAD && ent[i].e_state == S_NOT_EXECUTED) ent[i].e_state = S_ADDR_GENERATED;
        else ent[i].e_state = S_EXECUTED;
      end
    end
  endtask

  task automatic step(input bit hold = 1'b0);
    model_select();
    @(posedge clk);
    #1;
    model_commit();
    check_outputs();
    if (!hold) buffer_update();
  endtask

  // ---------------- stimulus helpers ----------------
  int perm [BUF_SIZE];
  int base;

  task automatic clear_all();
    for (int i = 0; i < BUF_SIZE; i++) ent[i] = '0;
  endtask

  task automatic put(input int i, input unit_e u, input state_e s, input int tag,
                     input bit j, input bit k, input bit a, input int nes);
    ent[i].e_state = s;
    ent[i].unit    = u;
    ent[i].tag     = tag_t'(tag);
    ent[i].j_rdy   = j;
    ent[i].k_rdy   = k;
    ent[i].a_rdy   = a;
    ent[i].number_of_early_store_ops = BUF_SIZE_LOG'(nes);
  endtask

  function automatic tag_t slot_tag(input int i);
    return tag_t'(base + 2 * perm[i] + int'($urandom_range(0, 1)));
  endfunction

  task automatic regenerate();
    base = int'($urandom_range(0, 31));
    oldest_tag_i = tag_t'(base);
    for (int i = 0; i < BUF_SIZE; i++) perm[i] = i;
    for (int i = BUF_SIZE - 1; i > 0; i--) begin
      int j = int'($urandom_range(0, i));
      int t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < BUF_SIZE; i++)
      put(i, unit_e'($urandom_range(0, 5)), state_e'($urandom_range(0, 3)), int'(slot_tag(i)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 2)));
  endtask

  task automatic mutate();
    for (int i = 0; i < BUF_SIZE; i++) begin
      case (ent[i].e_state)
        S_NOT_USED:
          if ($urandom_range(0, 3) == 0)
            put(i, unit_e'($urandom_range(0, 5)), S_NOT_EXECUTED, int'(slot_tag(i)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                int'($urandom_range(0, 2)));
        S_EXECUTED:
          if ($urandom_range(0, 3) == 0) ent[i].e_state = S_NOT_USED;
        S_NOT_EXECUTED: begin
          if ($urandom_range(0, 2) == 0) ent[i].j_rdy = 1'b1;
          if ($urandom_range(0, 2) == 0) ent[i].k_rdy = 1'b1;
        end
        default: begin
          if ($urandom_range(0, 2) == 0) ent[i].a_rdy = 1'b1;
          if (ent[i].number_of_early_store_ops != 0 && $urandom_range(0, 1) == 0)
            ent[i].number_of_early_store_ops--;
        end
      endcase
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset_i = 1'b1;
    flush_i = 1'b0;
    ex_ready_i = 2'b11;
    oldest_tag_i = '0;
    base = 0;
    clear_all();
    step();
    step();
    check("rst_valid", 32'(is_valid_execution_o), 32'd0);
    check("rst_div_busy", 32'(div_busy_o), 32'd0);
    check("rst_tag0", 32'(waked_tags_o[0]), 32'd0);
    reset_i = 1'b0;

    // Two ALU ops, oldest first across both ports
    oldest_tag_i = tag_t'(2);
    put(0, U_ALU, S_NOT_EXECUTED, 5, 1, 1, 0, 0);
    put(1, U_ALU, S_NOT_EXECUTED, 3, 1, 1, 0, 0);
    step();
    check("alu_p0_tag", 32'(waked_tags_o[0]), 32'd3);
    check("alu_p1_tag", 32'(waked_tags_o[1]), 32'd5);
    check("alu_p0_mode", 32'(ex_modes_o[0]), 32'(EX_NORMAL));
    check("alu_p1_mode", 32'(ex_modes_o[1]), 32'(EX_NORMAL));
    step();
    check("alu_no_reissue", 32'(is_valid_execution_o), 32'd0);

    // Divider occupancy
    clear_all();
    put(2, U_DIV, S_NOT_EXECUTED, 4, 1, 1, 0, 0);
    put(3, U_DIV, S_NOT_EXECUTED, 6, 1, 1, 0, 0);
    step();
    check("div1_tag", 32'(waked_tags_o[0]), 32'd4);
    check("div1_busy", 32'(div_busy_o), 32'd1);
    for (int k = 0; k < DIV_LAT - 1; k++) begin
      step();
      check("div_wait_valid", 32'(is_valid_execution_o[0]), 32'd0);
      check("div_wait_busy", 32'(div_busy_o), 32'd1);
    end
    step();
    check("div_zero_busy", 32'(div_busy_o), 32'd0);
    check("div_zero_valid", 32'(is_valid_execution_o[0]), 32'd0);
    step();
    check("div2_valid", 32'(is_valid_execution_o[0]), 32'd1);
    check("div2_tag", 32'(waked_tags_o[0]), 32'd6);

    // Load: address phase, blocked by early stores, then memory phase
    clear_all();
    put(4, U_LOAD, S_NOT_EXECUTED, 7, 1, 0, 1, 2);
    step();
    check("ld_addr_valid", 32'(is_valid_execution_o[1]), 32'd1);
    check("ld_addr_tag", 32'(waked_tags_o[1]), 32'd7);
    check("ld_addr_mode", 32'(ex_modes_o[1]), 32'(EX_GEN_ADDR));
    step();
    step();
    check("ld_blocked", 32'(is_valid_execution_o[1]), 32'd0);
    ent[4].number_of_early_store_ops = '0;
    step();
    check("ld_mem_valid", 32'(is_valid_execution_o[1]), 32'd1);
    check("ld_mem_mode", 32'(ex_modes_o[1]), 32'(EX_NORMAL));

    // Tag wrap-around
    clear_all();
    oldest_tag_i = tag_t'(30);
    put(0, U_ALU, S_NOT_EXECUTED, 1, 1, 1, 0, 0);
    put(1, U_ALU, S_NOT_EXECUTED, 31, 1, 1, 0, 0);
    step();
    check("wrap_p0_tag", 32'(waked_tags_o[0]), 32'd31);
    check("wrap_p1_tag", 32'(waked_tags_o[1]), 32'd1);

    // State held one cycle after issue: no re-issue
    clear_all();
    oldest_tag_i = '0;
    ex_ready_i = 2'b01;
    put(0, U_ALU, S_NOT_EXECUTED, 9, 1, 1, 0, 0);
    step(1'b1);
    check("hold_issue", 32'(waked_tags_o[0]), 32'd9);
    step(1'b1);
    check("hold_no_reissue", 32'(is_valid_execution_o[0]), 32'd0);
    ent[0].e_state = S_EXECUTED;
    ex_ready_i = 2'b11;

    // Flush clears outputs and pending bookkeeping
    clear_all();
    put(1, U_ALU, S_NOT_EXECUTED, 10, 1, 1, 0, 0);
    put(2, U_ALU, S_NOT_EXECUTED, 11, 1, 1, 0, 0);
    step(1'b1);
    flush_i = 1'b1;
    step(1'b1);
    check("flush_valid", 32'(is_valid_execution_o), 32'd0);
    check("flush_tag1", 32'(waked_tags_o[1]), 32'd0);
    check("flush_idx0", 32'(issue_index_o[0]), 32'd0);
    flush_i = 1'b0;
    step();
    check("reissue_valid", 32'(is_valid_execution_o), 32'd3);
    check("reissue_tag0", 32'(waked_tags_o[0]), 32'd10);

    // Port 0 stalled: port 1 takes the older ALU, store waits
    clear_all();
    oldest_tag_i = tag_t'(2);
    ex_ready_i = 2'b10;
    put(0, U_STORE, S_NOT_EXECUTED, 3, 1, 1, 0, 0);
    put(1, U_ALU, S_NOT_EXECUTED, 2, 1, 1, 0, 0);
    step();
    check("stall_p0_valid", 32'(is_valid_execution_o[0]), 32'd0);
    check("stall_p1_tag", 32'(waked_tags_o[1]), 32'd2);
    step();
    check("store_tag", 32'(waked_tags_o[1]), 32'd3);
    check("store_mode", 32'(ex_modes_o[1]), 32'(EX_GEN_ADDR));
    ex_ready_i = 2'b11;

    // Reset while the divider is busy
    clear_all();
    repeat (10) step();
    put(0, U_DIV, S_NOT_EXECUTED, 5, 1, 1, 0, 0);
    step();
    check("div3_busy", 32'(div_busy_o), 32'd1);
    reset_i = 1'b1;
    step();
    check("rst_mid_busy", 32'(div_busy_o), 32'd0);
    reset_i = 1'b0;

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc % 40 == 0) begin
        regenerate();
        flush_i = 1'b1;
      end else begin
        flush_i = ($urandom_range(0, 29) == 0);
      end
      ex_ready_i = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      step();
      mutate();
    end
    flush_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
